// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request controller: source count,
// cause codes, FSM encoding and small code/priority helpers.
package irq_pkg;

    localparam int NSRC        = 3;
    localparam int STACK_DEPTH = 3;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_SRC0 = 2'd1;
    localparam logic [1:0] CODE_SRC1 = 2'd2;
    localparam logic [1:0] CODE_SRC2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT0 = 2'd2
    } irq_state_e;

    // Cause code for source index src (code 0 is reserved for "none").
    function automatic logic [1:0] src_to_code(input logic [1:0] src);
        return src + 2'd1;
    endfunction

    // Index of the highest set bit; higher index means higher priority.
    function automatic logic [1:0] highest_src(input logic [NSRC-1:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (vec[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one raw asynchronous line followed by a
// rising-edge detector on the synchronised level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            last_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse per 0->1 transition; a held level never re-arms.
    assign rise = sync_reg[SYNC_STAGES-1] & ~last_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request controller feeding the CP0 cause/EPC/IE logic.
// Define IRQ_NESTED_EN for a 3-deep in-service stack allowing preemption.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             in_CLK,
    input  logic             in_RST_N,
    input  logic [NSRC-1:0]  in_IRQ,
    input  logic             in_IE,
    input  logic [3:0]       in_INM,
    input  logic             in_ack,
    input  logic             in_eret,
    output logic [1:0]       out_code,
    output logic             out_BK,
    output logic             out_NIE,
    output logic [NSRC-1:0]  out_pending,
    output logic [1:0]       out_level
);

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending_reg;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] clear_vec;
    logic [NSRC-1:0] unmasked;
    logic [NSRC-1:0] prio_gate;
    logic [NSRC-1:0] elig;
    logic [1:0]      winner;
    logic            any_elig;
    logic            ack_take;
    logic            sel_blocked;
    logic [1:0]      level;

    irq_state_e      state_reg;
    logic [1:0]      sel_reg;
    logic [1:0]      code_reg;
    logic            bk_reg;

    logic            unused_inm;
    assign unused_inm = in_INM[3];

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (in_CLK),
            .rst_n (in_RST_N),
            .raw   (in_IRQ[gi]),
            .rise  (rise[gi])
        );
    end

    // Priority gate: which sources may interrupt the current in-service level.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_gate
`ifdef IRQ_NESTED_EN
        assign prio_gate[gi] = (src_to_code(2'(gi)) > level);
`else
        assign prio_gate[gi] = (level == CODE_NONE);
`endif
    end

    assign unmasked = pending_reg & ~in_INM[NSRC-1:0];
    assign elig     = unmasked & prio_gate;
    assign any_elig = |elig;
    assign winner   = highest_src(elig);

    assign ack_take    = (state_reg == REQ) && in_ack;
    assign sel_blocked = !in_IE || in_INM[sel_reg];

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_clear
        assign clear_vec[gi] = ack_take && (sel_reg == 2'(gi));
    end

    // A new edge arriving with the ack that clears the same bit keeps it set.
    assign pending_next = (pending_reg & ~clear_vec) | rise;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

`ifdef IRQ_NESTED_EN
    logic [1:0] stack_reg [STACK_DEPTH];
    logic [1:0] depth_reg;
    logic [1:0] depth_popped;

    // eret pops before the ack pushes when both land in the same cycle.
    assign depth_popped = (in_eret && (depth_reg != 2'd0)) ? depth_reg - 2'd1 : depth_reg;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            depth_reg <= 2'd0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_reg[i] <= CODE_NONE;
            end
        end else if (ack_take) begin
            stack_reg[depth_popped] <= src_to_code(sel_reg);
            depth_reg               <= depth_popped + 2'd1;
        end else begin
            depth_reg <= depth_popped;
        end
    end

    assign level = (depth_reg == 2'd0) ? CODE_NONE : stack_reg[depth_reg - 2'd1];
`else
    logic [1:0] level_reg;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            level_reg <= CODE_NONE;
        end else if (ack_take) begin
            level_reg <= src_to_code(sel_reg);
        end else if (in_eret) begin
            level_reg <= CODE_NONE;
        end
    end

    assign level = level_reg;
`endif

    // Request sequencer: the cause code only moves 0 -> nonzero -> 0, so CP0
    // sees a fresh rising edge for every request it is asked to take.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            code_reg  <= CODE_NONE;
            bk_reg    <= 1'b0;
        end else begin
            bk_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_IE && any_elig) begin
                        sel_reg   <= winner;
                        code_reg  <= src_to_code(winner);
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (in_ack) begin
                        code_reg  <= CODE_NONE;
                        bk_reg    <= 1'b1;
                        state_reg <= WAIT0;
                    end else if (sel_blocked) begin
                        code_reg  <= CODE_NONE;
                        state_reg <= IDLE;
                    end
                end
                WAIT0: begin
                    code_reg  <= CODE_NONE;
                    state_reg <= IDLE;
                end
                default: begin
                    code_reg  <= CODE_NONE;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_code    = code_reg;
    assign out_BK      = bk_reg;
    assign out_NIE     = in_eret | ~bk_reg;
    assign out_pending = pending_reg;
    assign out_level   = level;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised scoreboard bench for irq_ctrl against an abstract request model;
// follows IRQ_NESTED_EN for the expected preemption behaviour.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] irq;
    logic       ie;
    logic [3:0] inm;
    logic       ack;
    logic       eret;
    logic [1:0] out_code;
    logic       out_BK;
    logic       out_NIE;
    logic [2:0] out_pending;
    logic [1:0] out_level;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .in_CLK      (clk),
        .in_RST_N    (rst_n),
        .in_IRQ      (irq),
        .in_IE       (ie),
        .in_INM      (inm),
        .in_ack      (ack),
        .in_eret     (eret),
        .out_code    (out_code),
        .out_BK      (out_BK),
        .out_NIE     (out_NIE),
        .out_pending (out_pending),
        .out_level   (out_level)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_bk;
        logic [1:0] val;
    } exp_t;
    exp_t exp_q[$];

    // Abstract model: set of pending sources, stack of in-service codes,
    // and whether a request is currently being presented (and for whom).
    bit [2:0] m_pend;
    int       m_stack[$];
    bit       m_req;
    int       m_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_level();
        return (m_stack.size() == 0) ? 0 : m_stack[$];
    endfunction

    function automatic bit [2:0] m_gate();
        bit [2:0] g;
        g = 3'b000;
        for (int k = 0; k < 3; k++) begin
`ifdef IRQ_NESTED_EN
            if (k + 1 > m_level()) g[k] = 1'b1;
`else
            if (m_level() == 0) g[k] = 1'b1;
`endif
        end
        return g;
    endfunction

    function automatic void push_exp(input bit is_bk, input int val);
        exp_t e;
        e.is_bk = is_bk;
        e.val   = 2'(val);
        exp_q.push_back(e);
    endfunction

    function automatic void m_update();
        bit [2:0] el;
        if (m_req && (!ie || inm[m_sel])) m_req = 1'b0;
        if (!m_req && ie) begin
            el = m_pend & ~inm[2:0] & m_gate();
            for (int k = 2; k >= 0; k--) begin
                if (!m_req && el[k]) begin
                    m_req = 1'b1;
                    m_sel = k;
                    push_exp(1'b0, k + 1);
                end
            end
        end
    endfunction

    function automatic void m_reset();
        m_pend = 3'b000;
        m_stack.delete();
        m_req = 1'b0;
        m_sel = 0;
        exp_q.delete();
    endfunction

    // Monitor: pops the scoreboard whenever the DUT raises a code or a BK pulse.
    logic [1:0] prev_code = 2'd0;
    bit         prev_bk   = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_code = 2'd0;
            prev_bk   = 1'b0;
        end else begin
            if (prev_code == 2'd0 && out_code != 2'd0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_code", out_code, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_kind_code", 32'(mon_e.is_bk), 0);
                    chk("sb_code", out_code, mon_e.val);
                end
            end
            if (prev_code != 2'd0 && out_code != 2'd0) chk("code_stable", out_code, prev_code);
            if (out_BK) begin
                if (prev_bk) chk("bk_width", 2, 1);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_bk", out_BK, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_kind_bk", 32'(mon_e.is_bk), 1);
                    chk("sb_bk_nie", out_NIE, 0);
                    chk("sb_bk_level", out_level, mon_e.val);
                end
            end
            prev_code = out_code;
            prev_bk   = out_BK;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_code"}, out_code, m_req ? m_sel + 1 : 0);
        chk({tag, "_pending"}, out_pending, m_pend);
        chk({tag, "_level"}, out_level, m_level());
        step();
    endtask

    task automatic raise(input bit [2:0] bits);
        irq = bits;
        m_pend |= bits;
        m_update();
        settle(4);
        irq = 3'b000;
        settle(4);
    endtask

    task automatic set_ctrl(input bit new_ie, input bit [3:0] new_inm);
        ie  = new_ie;
        inm = new_inm;
        m_update();
        settle(4);
    endtask

    task automatic do_ack();
        bit taken;
        taken = m_req;
        ack = 1'b1;
        if (m_req) begin
            m_pend[m_sel] = 1'b0;
            m_stack.push_back(m_sel + 1);
            m_req = 1'b0;
            push_exp(1'b1, m_sel + 1);
        end
        m_update();
        step();
        ack = 1'b0;
        @(negedge clk);
        chk("ack_bk", out_BK, taken);
        chk("ack_code_low", out_code, 0);
        step();
        @(negedge clk);
        chk("wait0_code_low", out_code, 0);
        chk("wait0_bk_low", out_BK, 0);
        step();
        settle(4);
    endtask

    task automatic do_eret();
        eret = 1'b1;
        if (m_stack.size() != 0) void'(m_stack.pop_back());
        m_update();
        @(negedge clk);
        chk("eret_nie", out_NIE, 1);
        step();
        eret = 1'b0;
        settle(5);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 6; i++) begin
            if (m_req) do_ack();
            else if (m_stack.size() != 0) do_eret();
            check_state(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        irq   = 3'b000;
        ie    = 1'b0;
        inm   = 4'b0000;
        ack   = 1'b0;
        eret  = 1'b0;
        m_reset();
        #1;
        chk("rst_code", out_code, 0);
        chk("rst_bk", out_BK, 0);
        chk("rst_nie", out_NIE, 1);
        chk("rst_pending", out_pending, 0);
        chk("rst_level", out_level, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle(2);

        // Basic request with exact synchroniser latency.
        ie  = 1'b1;
        inm = 4'b0000;
        irq = 3'b010;
        m_pend[1] = 1'b1;
        m_update();
        repeat (3) @(negedge clk);
        chk("lat_pending_early", out_pending, 0);
        @(negedge clk);
        chk("lat_pending", out_pending, 3'b010);
        chk("lat_code_early", out_code, 0);
        @(negedge clk);
        chk("lat_code", out_code, 2);
        step();
        irq = 3'b000;
        settle(3);
        check_state("basic_req");
        do_ack();
        check_state("basic_ack");
        do_eret();
        check_state("basic_eret");

        // Priority between simultaneous sources.
        raise(3'b101);
        check_state("prio_req");
        do_ack();
        check_state("prio_ack");
        do_eret();
        check_state("prio_reacq");
        drain("prio_drain");

        // Masking, then unmasking within two cycles.
        set_ctrl(1'b1, 4'b0100);
        raise(3'b100);
        check_state("mask_hold");
        inm = 4'b0000;
        m_update();
        repeat (2) @(negedge clk);
        chk("unmask_code", out_code, 3);
        step();
        settle(2);
        drain("mask_drain");

        // Withdrawal by dropping IE before the ack.
        raise(3'b010);
        check_state("wd_req");
        set_ctrl(1'b0, 4'b0000);
        check_state("wd_drop");
        set_ctrl(1'b1, 4'b0000);
        check_state("wd_reacq");
        drain("wd_drain");

        // Preemption attempt while source 0 is in service.
        raise(3'b001);
        do_ack();
        check_state("nest_base");
        raise(3'b100);
        check_state("nest_req");
        if (m_req) do_ack();
        check_state("nest_ack");
        do_eret();
        check_state("nest_eret1");
        drain("nest_drain");

        // Randomised operation mix.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1: raise(3'($urandom_range(1, 7)));
                2: set_ctrl($urandom_range(0, 3) != 0,
                            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
                3, 5: do_ack();
                default: do_eret();
            endcase
            check_state("rand");
        end
        chk("sb_drained", exp_q.size(), 0);

        // Asynchronous reset while a request is being presented.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_reset();
        set_ctrl(1'b1, 4'b0000);
        raise(3'b100);
        check_state("areset_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_code", out_code, 0);
        chk("areset_bk", out_BK, 0);
        chk("areset_nie", out_NIE, 1);
        chk("areset_pending", out_pending, 0);
        chk("areset_level", out_level, 0);
        m_reset();
        ack = 1'b1;
        @(negedge clk);
        chk("areset_hold_bk", out_BK, 0);
        step();
        ack = 1'b0;
        rst_n = 1'b1;
        settle(3);
        check_state("areset_post");
        chk("sb_final", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt request controller that sits directly upstream of the CP0 register block.
- Synchronises three external interrupt lines and latches them as pending requests. Applies the CP0 mask (INM) and global enable (IE), then selects the highest-priority request.
- Drives the cause code whose rising edge makes CP0 capture EPC.
- Sequences the break (BK) and eret handshakes that make CP0 clear and restore IE.

Parameters:
- NSRC, 3, number of interrupt sources; fixed at 3 because the code is 2 bits and code 0 means "none".
- SYNC_STAGES, 2, synchroniser flops per raw input line; minimum 2.

Ports:
- in_CLK  input  1  system clock; everything changes on the rising edge.
- in_RST_N  input  1  reset, asynchronous and active-low.
- in_IRQ  input  3  raw asynchronous request lines; bit 2 has the highest priority.
- in_IE  input  1  global interrupt enable, from CP0 IE bit 0.
- in_INM  input  4  interrupt mask from CP0; bit k=1 masks source k (k=0..2); bit 3 is ignored.
- in_ack  input  1  pipeline has flushed and redirected the PC to the handler; one-cycle pulse.
- in_eret  input  1  eret is retiring in WB; one-cycle pulse.
- out_code  output  2  cause code: 0 = none, k+1 = source k requesting.
- out_BK  output  1  one-cycle pulse telling CP0 to load IE from out_NIE on interrupt entry.
- out_NIE  output  1  new IE value sent to CP0 with out_BK or in_eret.
- out_pending  output  3  latched pending bits, visible for debug and for CP0 read-back.
- out_level  output  2  code of the interrupt currently in service; 0 when none is in service.

Behaviour:
- Reset (in_RST_N=0, asynchronous):
  - Clears synchronisers, pending bits, in-service state and the FSM.
  - Output values during reset: out_code=0, out_BK=0, out_NIE=1, out_pending=0, out_level=0.
- Synchronise and detect edges:
  - Each in_IRQ bit passes through SYNC_STAGES flops.
  - A 0->1 transition on a synchronised bit sets pending[k] on the next edge.
  - Latency from raw edge to pending is SYNC_STAGES+1 cycles.
  - Levels are not re-armed: the line must fall and rise again to request again.
- Eligibility:
  - elig = pending & ~in_INM[2:0] & prio_gate. prio_gate allows only sources with higher priority than out_level; when out_level=0, all sources are allowed.
  - winner = the highest set bit of elig.
- FSM states:
  - IDLE: if in_IE=1 and elig!=0, latch the winner into sel and go to REQ.
  - REQ: out_code = sel+1, held stable. When in_ack=1: clear pending[sel], set out_level = sel+1, pulse out_BK with out_NIE=0, then go to WAIT0.
    - If in_IE drops or sel becomes masked before the ack, drop out_code to 0 and return to IDLE. pending[sel] is kept.
  - WAIT0: out_code=0 for exactly one cycle, so every request produces a fresh rising edge on the CP0 cause input; then go to IDLE.
- Code transitions: out_code only ever goes 0 -> nonzero -> 0; it never changes directly between two nonzero values.
- eret:
  - On in_eret, out_NIE=1 combinationally for that cycle.
  - The in-service level is popped on the next edge; without nesting, out_level becomes 0.
  - An eret with out_level=0 is ignored, apart from out_NIE=1.
- Simultaneous events:
  - A new edge on source k in the same cycle as an ack clearing pending[k]: the set wins, and the pending bit stays 1.
  - An eret and an ack in the same cycle: the pop happens first, then the push.
  - An ack while in IDLE or WAIT0 is ignored.
- Reset mid-operation: reset in REQ aborts immediately, out_code=0, and no BK pulse is produced.

Optional Feature:
- Macro: IRQ_NESTED_EN.
- Defined:
  - The in-service state is a 3-entry stack of codes, so a higher-priority request may preempt an active handler once the handler re-enables IE.
  - out_level is the top of the stack; eret pops one entry.
  - A push onto a full stack cannot occur, because priorities are strictly increasing.
- Not defined:
  - A single in-service register is used.
  - prio_gate blocks all requests while out_level!=0.
  - eret clears out_level to 0.

Decomposition:
- Shared package irq_pkg holds:
  - localparams CODE_NONE=2'd0 and CODE_SRC0..CODE_SRC2;
  - the FSM state encodings IDLE, REQ, WAIT0;
  - NSRC.
- Natural sub-module: irq_sync_edge, a per-bit synchroniser plus rising-edge detector, instantiated NSRC times.

Test Plan:
- Basic request: reset, in_IE=1, in_INM=0, pulse in_IRQ[1].
  - pending=3'b010 after 3 cycles; out_code=2 on the next cycle.
  - Ack -> out_BK=1 with out_NIE=0 for 1 cycle; out_level=2; out_code=0 for 1 cycle.
- Priority: raise in_IRQ[0] and in_IRQ[2] in the same cycle -> out_code=3. After the ack, pending=3'b001. After eret plus a reacquire, out_code=1.
- Masking: in_INM=4'b0100, pulse in_IRQ[2] -> pending=3'b100, out_code stays 0. Clear the mask -> out_code=3 within 2 cycles.
- Withdrawal: in REQ with out_code=2, drop in_IE before the ack -> out_code=0, pending[1] stays 1, no BK pulse.
- Nesting (IRQ_NESTED_EN):
  - With source 0 in service and IE=1, pulse in_IRQ[2] -> out_code=3. After the ack, out_level=3.
  - eret -> out_level=1, out_NIE=1 during the eret cycle.
  - Without the macro, the same stimulus gives out_code=0 until the eret.
- Async reset asserted while out_code=3 -> all outputs return to their reset values immediately, with no clock edge needed.
